// File: rtl/vram_pkg.sv
// Shared constants for the text-VRAM arbiter slice: geometry, requester ids
// and the arbiter state encoding.
package vram_pkg;

  localparam int VRAM_ADDR_W = 11;
  localparam int VRAM_DATA_W = 8;
  localparam int ROW_W       = 5;
  localparam int COL_W       = 6;
  localparam int LAST_ROW    = 16;
  localparam int LAST_COL    = 59;

  localparam int REQ_WRITER  = 0;
  localparam int REQ_SCROLL  = 1;
  localparam int REQ_CLEAR   = 2;

  typedef enum logic {
    ST_FREE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/vram_arbiter_rr_picker.sv
// Round-robin picker: one-hot select of the first requester found searching
// upward from i_ptr+1 with wrap-around. Purely combinational.
module rr_picker #(
  parameter int N_REQ = 3,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_pick
);

  logic             found;
  logic [IDX_W-1:0] idx;

  // Walk the offsets 1..N_REQ from the pointer; the first hit wins.
  always_comb begin
    o_pick = '0;
    found  = 1'b0;
    idx    = '0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = IDX_W'((int'(i_ptr) + off) % N_REQ);
      if (!found && i_req[idx]) begin
        o_pick[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single text-VRAM port between N_REQ engines.
// Round-robin grant with optional per-requester lock for bursts, registered
// VRAM command, and a tag pipeline that routes read data back to its issuer.
// Optional feature: define VRAM_ARB_LOCK_TIMEOUT_EN to enable the lock
// watchdog (force-release after LOCK_MAX locked cycles, sticky o_lock_err).
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int N_REQ    = 3,
  parameter int ADDR_W   = VRAM_ADDR_W,
  parameter int DATA_W   = VRAM_DATA_W,
  parameter int RD_LAT   = 1,
  parameter int LOCK_MAX = 4096
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ-1:0]        i_lock,
  input  logic [N_REQ-1:0]        i_we,
  input  logic [N_REQ*ADDR_W-1:0] i_addr,
  input  logic [N_REQ*DATA_W-1:0] i_din,
  output logic [N_REQ-1:0]        o_gnt,
  output logic [N_REQ-1:0]        o_rvalid,
  output logic [DATA_W-1:0]       o_rdata,
  output logic                    o_vram_ce,
  output logic                    o_vram_wre,
  output logic [ADDR_W-1:0]       o_vram_addr,
  output logic [DATA_W-1:0]       o_vram_din,
  input  logic [DATA_W-1:0]       i_vram_dout,
  output logic                    o_lock_err
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_t       state_reg;
  logic [IDX_W-1:0] owner_reg;
  logic [IDX_W-1:0] ptr_reg;
  logic [N_REQ-1:0] pick;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_idx;
  logic             xfer;
  logic             arb_free;
  logic             force_release;

  logic [ADDR_W-1:0] addr_arr [N_REQ];
  logic [DATA_W-1:0] din_arr  [N_REQ];

  logic [RD_LAT:0]   tag_valid_reg;
  logic [IDX_W-1:0]  tag_id_reg [RD_LAT+1];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign addr_arr[gi] = i_addr[gi*ADDR_W +: ADDR_W];
    assign din_arr[gi]  = i_din[gi*DATA_W +: DATA_W];
  end

  rr_picker #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_picker (
    .i_req  (i_req),
    .i_ptr  (ptr_reg),
    .o_pick (pick)
  );

  // The cycle the owner drops its lock already arbitrates as FREE.
  assign arb_free = (state_reg == ST_FREE) || !i_lock[owner_reg];

  // Grant: round-robin pick when free, else only the lock owner; none in reset.
  always_comb begin
    gnt = '0;
    if (!i_rst) begin
      if (arb_free)
        gnt = pick;
      else if (i_req[owner_reg])
        gnt[owner_reg] = 1'b1;
    end
  end

  // One-hot grant to index.
  always_comb begin
    gnt_idx = '0;
    for (int k = 0; k < N_REQ; k++)
      if (gnt[k]) gnt_idx = IDX_W'(k);
  end

  assign xfer  = |gnt;
  assign o_gnt = gnt;

  // Lock state, owner and round-robin pointer; watchdog release has priority.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= ST_FREE;
      owner_reg <= '0;
      ptr_reg   <= IDX_W'(N_REQ - 1);
    end else begin
      if (xfer)
        ptr_reg <= gnt_idx;
      if (force_release) begin
        state_reg <= ST_FREE;
      end else if (xfer && i_lock[gnt_idx]) begin
        state_reg <= ST_LOCKED;
        owner_reg <= gnt_idx;
      end else if (arb_free) begin
        state_reg <= ST_FREE;
      end
    end
  end

`ifdef VRAM_ARB_LOCK_TIMEOUT_EN
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic [CNT_W-1:0] lock_cnt_reg;
  logic             lock_err_reg;

  assign force_release = (state_reg == ST_LOCKED) && i_lock[owner_reg] &&
                         (lock_cnt_reg == CNT_W'(LOCK_MAX - 1));

  // Watchdog: count locked cycles, clear on release, latch the error flag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      lock_cnt_reg <= '0;
      lock_err_reg <= 1'b0;
    end else begin
      if ((state_reg == ST_LOCKED) && !arb_free && !force_release)
        lock_cnt_reg <= lock_cnt_reg + 1'b1;
      else
        lock_cnt_reg <= '0;
      if (force_release)
        lock_err_reg <= 1'b1;
    end
  end

  assign o_lock_err = lock_err_reg;
`else
  logic unused_lock_cfg;

  assign unused_lock_cfg = (LOCK_MAX > 0);
  assign force_release   = 1'b0;
  assign o_lock_err      = 1'b0;
`endif

  // Register the VRAM command one cycle after the transfer; addr/din hold when idle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_vram_ce   <= 1'b0;
      o_vram_wre  <= 1'b0;
      o_vram_addr <= '0;
      o_vram_din  <= '0;
    end else begin
      o_vram_ce  <= xfer;
      o_vram_wre <= xfer & i_we[gnt_idx];
      if (xfer) begin
        o_vram_addr <= addr_arr[gnt_idx];
        o_vram_din  <= din_arr[gnt_idx];
      end
    end
  end

  // Read tag pipeline: stage 0 aligns with the registered command, stage RD_LAT with VRAM data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tag_valid_reg <= '0;
      for (int s = 0; s <= RD_LAT; s++)
        tag_id_reg[s] <= '0;
    end else begin
      tag_valid_reg[0] <= xfer & ~i_we[gnt_idx];
      tag_id_reg[0]    <= gnt_idx;
      for (int s = 1; s <= RD_LAT; s++) begin
        tag_valid_reg[s] <= tag_valid_reg[s-1];
        tag_id_reg[s]    <= tag_id_reg[s-1];
      end
    end
  end

  // Return read data to the issuing requester for a single cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rvalid <= '0;
      o_rdata  <= '0;
    end else begin
      o_rvalid <= '0;
      if (tag_valid_reg[RD_LAT]) begin
        o_rvalid[tag_id_reg[RD_LAT]] <= 1'b1;
        o_rdata                      <= i_vram_dout;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter (N_REQ=3, RD_LAT=1, LOCK_MAX=8) with a
// behavioural single-port VRAM preloaded with mem[a] = a[7:0] ^ 8'h5A.
module tb_vram_arbiter;

  logic        clk;
  logic        rst;
  logic [2:0]  req, lock, we;
  logic [10:0] a0, a1, a2;
  logic [7:0]  d0, d1, d2;
  logic [2:0]  gnt, rvalid;
  logic [7:0]  rdata;
  logic        vram_ce, vram_wre;
  logic [10:0] vram_addr;
  logic [7:0]  vram_din;
  logic [7:0]  vram_dout;
  logic        lock_err;

  logic [7:0]  mem [2048];

  int n_total = 0;
  int n_pass  = 0;

  vram_arbiter #(
    .N_REQ(3), .ADDR_W(11), .DATA_W(8), .RD_LAT(1), .LOCK_MAX(8)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_lock      (lock),
    .i_we        (we),
    .i_addr      ({a2, a1, a0}),
    .i_din       ({d2, d1, d0}),
    .o_gnt       (gnt),
    .o_rvalid    (rvalid),
    .o_rdata     (rdata),
    .o_vram_ce   (vram_ce),
    .o_vram_wre  (vram_wre),
    .o_vram_addr (vram_addr),
    .o_vram_din  (vram_din),
    .i_vram_dout (vram_dout),
    .o_lock_err  (lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM model: one-cycle registered read, write on ce & wre.
  always @(posedge clk) begin
    if (vram_ce) begin
      if (vram_wre) mem[vram_addr] <= vram_din;
      else          vram_dout      <= mem[vram_addr];
    end
  end

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  lock;
    logic [2:0]  we;
    logic [10:0] a1;
    logic [2:0]  gnt;
    logic        ce;
    logic        wre;
    logic [2:0]  rvalid;
    logic [7:0]  rdata;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input logic r, input logic [2:0] rq, input logic [2:0] lk, input logic [2:0] w);
    @(posedge clk);
    #1;
    rst = r; req = rq; lock = lk; we = w;
    @(negedge clk);
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) begin
      logic [10:0] av;
      av = 11'(a);
      mem[a] = av[7:0] ^ 8'h5A;
    end
    vram_dout = 8'h00;
    rst = 1'b1; req = 3'b111; lock = 3'b000; we = 3'b111;
    a0 = 11'h010; a1 = 11'h100; a2 = 11'h020;
    d0 = 8'hA0;   d1 = 8'hB1;   d2 = 8'hC2;

    //          rst   req     lock    we      a1       gnt     ce    wre   rvalid  rdata
    vecs[0]  = '{1'b1, 3'b111, 3'b000, 3'b111, 11'h100, 3'b000, 1'b0, 1'b0, 3'b000, 8'h00};
    vecs[1]  = '{1'b1, 3'b111, 3'b000, 3'b111, 11'h100, 3'b000, 1'b0, 1'b0, 3'b000, 8'h00};
    vecs[2]  = '{1'b0, 3'b111, 3'b000, 3'b111, 11'h100, 3'b001, 1'b0, 1'b0, 3'b000, 8'h00};
    vecs[3]  = '{1'b0, 3'b111, 3'b000, 3'b111, 11'h100, 3'b010, 1'b1, 1'b1, 3'b000, 8'h00};
    vecs[4]  = '{1'b0, 3'b111, 3'b000, 3'b111, 11'h100, 3'b100, 1'b1, 1'b1, 3'b000, 8'h00};
    vecs[5]  = '{1'b0, 3'b111, 3'b000, 3'b111, 11'h100, 3'b001, 1'b1, 1'b1, 3'b000, 8'h00};
    vecs[6]  = '{1'b0, 3'b111, 3'b000, 3'b111, 11'h100, 3'b010, 1'b1, 1'b1, 3'b000, 8'h00};
    vecs[7]  = '{1'b0, 3'b111, 3'b000, 3'b111, 11'h100, 3'b100, 1'b1, 1'b1, 3'b000, 8'h00};
    vecs[8]  = '{1'b0, 3'b000, 3'b000, 3'b111, 11'h100, 3'b000, 1'b1, 1'b1, 3'b000, 8'h00};
    vecs[9]  = '{1'b0, 3'b010, 3'b010, 3'b000, 11'h040, 3'b010, 1'b0, 1'b0, 3'b000, 8'h00};
    vecs[10] = '{1'b0, 3'b111, 3'b010, 3'b000, 11'h041, 3'b010, 1'b1, 1'b0, 3'b000, 8'h00};
    vecs[11] = '{1'b0, 3'b111, 3'b010, 3'b000, 11'h042, 3'b010, 1'b1, 1'b0, 3'b000, 8'h00};
    vecs[12] = '{1'b0, 3'b111, 3'b010, 3'b000, 11'h043, 3'b010, 1'b1, 1'b0, 3'b010, 8'h1A};
    vecs[13] = '{1'b0, 3'b101, 3'b000, 3'b101, 11'h043, 3'b100, 1'b1, 1'b0, 3'b010, 8'h1B};
    vecs[14] = '{1'b0, 3'b101, 3'b000, 3'b101, 11'h043, 3'b001, 1'b1, 1'b1, 3'b010, 8'h18};
    vecs[15] = '{1'b0, 3'b000, 3'b000, 3'b000, 11'h043, 3'b000, 1'b1, 1'b1, 3'b010, 8'h19};
    vecs[16] = '{1'b0, 3'b000, 3'b000, 3'b000, 11'h043, 3'b000, 1'b0, 1'b0, 3'b000, 8'h00};

    @(posedge clk);  // extra reset edge so registered outputs are defined
    for (int i = 0; i < 17; i++) begin
      @(posedge clk);
      #1;
      rst = vecs[i].rst; req = vecs[i].req; lock = vecs[i].lock;
      we = vecs[i].we;   a1 = vecs[i].a1;
      @(negedge clk);
      $display("row %0d: gnt=%b ce=%b wre=%b rvalid=%b rdata=%h", i, gnt, vram_ce, vram_wre, rvalid, rdata);
      check($sformatf("row%0d gnt", i),    32'(gnt),      32'(vecs[i].gnt));
      check($sformatf("row%0d ce", i),     32'(vram_ce),  32'(vecs[i].ce));
      check($sformatf("row%0d wre", i),    32'(vram_wre), 32'(vecs[i].wre));
      check($sformatf("row%0d rvalid", i), 32'(rvalid),   32'(vecs[i].rvalid));
      if (vecs[i].rvalid != 3'b000)
        check($sformatf("row%0d rdata", i), 32'(rdata), 32'(vecs[i].rdata));
      check($sformatf("row%0d lock_err", i), 32'(lock_err), 32'd0);
    end

    // Write 0x41 to 0x085 then read it back on the next cycle.
    a0 = 11'h085; d0 = 8'h41;
    step(1'b0, 3'b001, 3'b000, 3'b001);
    $display("wr/rd write: gnt=%b", gnt);
    check("wr gnt", 32'(gnt), 32'b001);
    step(1'b0, 3'b001, 3'b000, 3'b000);
    $display("wr/rd read: gnt=%b wre=%b", gnt, vram_wre);
    check("rd gnt", 32'(gnt), 32'b001);
    check("wr wre", 32'(vram_wre), 32'd1);
    step(1'b0, 3'b000, 3'b000, 3'b000);
    check("rd wre", 32'(vram_wre), 32'd0);
    check("rd ce", 32'(vram_ce), 32'd1);
    step(1'b0, 3'b000, 3'b000, 3'b000);
    check("rd early rvalid", 32'(rvalid), 32'b000);
    step(1'b0, 3'b000, 3'b000, 3'b000);
    $display("wr/rd response: rvalid=%b rdata=%h", rvalid, rdata);
    check("rd rvalid", 32'(rvalid), 32'b001);
    check("rd rdata", 32'(rdata), 32'h41);

    // Reset the cycle after a read is granted: the read must vanish.
    a0 = 11'h010;
    step(1'b0, 3'b001, 3'b000, 3'b000);
    check("midrd gnt", 32'(gnt), 32'b001);
    step(1'b1, 3'b001, 3'b000, 3'b000);
    check("midrd gnt in reset", 32'(gnt), 32'b000);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 3'b000, 3'b000, 3'b000);
      $display("post-reset %0d: rvalid=%b ce=%b", i, rvalid, vram_ce);
      check($sformatf("midrd rvalid%0d", i), 32'(rvalid), 32'b000);
      check($sformatf("midrd ce%0d", i), 32'(vram_ce), 32'd0);
    end

    // Requester 2 locks, then idles holding the lock while requester 0 waits.
    step(1'b0, 3'b100, 3'b100, 3'b000);
    check("lk gnt", 32'(gnt), 32'b100);
    for (int c = 1; c <= 8; c++) begin
      step(1'b0, 3'b001, 3'b100, 3'b000);
      check($sformatf("lk idle gnt c%0d", c), 32'(gnt), 32'b000);
    end
    check("lk err before limit", 32'(lock_err), 32'd0);
    step(1'b0, 3'b001, 3'b100, 3'b000);
    $display("lock cycle 9: gnt=%b lock_err=%b", gnt, lock_err);
`ifdef VRAM_ARB_LOCK_TIMEOUT_EN
    check("lk timeout gnt", 32'(gnt), 32'b001);
    check("lk timeout err", 32'(lock_err), 32'd1);
`else
    check("lk persist gnt", 32'(gnt), 32'b000);
    check("lk persist err", 32'(lock_err), 32'd0);
`endif
    step(1'b0, 3'b001, 3'b000, 3'b000);
    $display("lock released: gnt=%b lock_err=%b", gnt, lock_err);
    check("lk release gnt", 32'(gnt), 32'b001);
`ifdef VRAM_ARB_LOCK_TIMEOUT_EN
    check("lk err sticky", 32'(lock_err), 32'd1);
`else
    check("lk err tied", 32'(lock_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
